// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding mux selects,
// the memory-wait FSM state, and the wait-counter width helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_e;

  // A zero-latency memory still needs a 1-bit counter so the declaration stays legal.
  function automatic int wait_cnt_width(input int mem_latency);
    return (mem_latency > 0) ? $clog2(mem_latency + 1) : 1;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Bundle between the pipeline registers and the hazard controller.
// The datapath side uses the master modport, the hazard unit uses the slave modport.
interface hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) ();
  import hazard_pkg::*;

  logic [REG_ADDR_WIDTH-1:0] rs1_d_i;
  logic [REG_ADDR_WIDTH-1:0] rs2_d_i;
  logic [REG_ADDR_WIDTH-1:0] rs1_e_i;
  logic [REG_ADDR_WIDTH-1:0] rs2_e_i;
  logic [REG_ADDR_WIDTH-1:0] rd_e_i;
  logic                      is_load_e_i;
  logic                      pc_src_e_i;
  logic [REG_ADDR_WIDTH-1:0] rd_m_i;
  logic [REG_ADDR_WIDTH-1:0] rd_w_i;
  logic                      reg_write_m_i;
  logic                      reg_write_w_i;
  logic                      dmem_req_m_i;

  fwd_sel_e                  forward_a_e_o;
  fwd_sel_e                  forward_b_e_o;
  logic                      stall_f_o;
  logic                      stall_d_o;
  logic                      stall_e_o;
  logic                      stall_m_o;
  logic                      flush_d_o;
  logic                      flush_e_o;
  logic                      flush_w_o;
  logic [CNT_WIDTH-1:0]      stall_cnt_o;
  logic [CNT_WIDTH-1:0]      flush_cnt_o;

  modport master (
    output rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, is_load_e_i, pc_src_e_i,
    output rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i, dmem_req_m_i,
    input  forward_a_e_o, forward_b_e_o,
    input  stall_f_o, stall_d_o, stall_e_o, stall_m_o,
    input  flush_d_o, flush_e_o, flush_w_o,
    input  stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  rs1_d_i, rs2_d_i, rs1_e_i, rs2_e_i, rd_e_i, is_load_e_i, pc_src_e_i,
    input  rd_m_i, rd_w_i, reg_write_m_i, reg_write_w_i, dmem_req_m_i,
    output forward_a_e_o, forward_b_e_o,
    output stall_f_o, stall_d_o, stall_e_o, stall_m_o,
    output flush_d_o, flush_e_o, flush_w_o,
    output stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/fwd_select.sv
// Operand forwarding select for one execute-stage source register.
// The M-stage result is younger than the W-stage result, so it wins a tie.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_e,
  input  logic [REG_ADDR_WIDTH-1:0] rd_m,
  input  logic [REG_ADDR_WIDTH-1:0] rd_w,
  input  logic                      reg_write_m,
  input  logic                      reg_write_w,
  output fwd_sel_e                  sel
);

  logic hit_m;
  logic hit_w;

  // x0 is hardwired to zero, so a write to it must never be forwarded.
  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

  always_comb begin
    sel = FWD_RF;
    if (hit_m) begin
      sel = FWD_MEM;
    end else if (hit_w) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: forwarding selects, stall/flush controls and the
// data-memory wait FSM. Define HAZARD_STATS_EN to build the stall/flush counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_LATENCY    = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  hazard_unit_if.slave hz
);

  localparam int              WAIT_W    = wait_cnt_width(MEM_LATENCY);
  localparam bit              HAS_WAIT  = (MEM_LATENCY > 0);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

  hz_state_e         state_q;
  hz_state_e         state_d;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;

  logic ms;
  logic lu;
  logic stall_f;
  logic stall_d;
  logic stall_e;
  logic stall_m;
  logic flush_d;
  logic flush_e;
  logic flush_w;

  fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e        (hz.rs1_e_i),
    .rd_m        (hz.rd_m_i),
    .rd_w        (hz.rd_w_i),
    .reg_write_m (hz.reg_write_m_i),
    .reg_write_w (hz.reg_write_w_i),
    .sel         (hz.forward_a_e_o)
  );

  fwd_select #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e        (hz.rs2_e_i),
    .rd_m        (hz.rd_m_i),
    .rd_w        (hz.rd_w_i),
    .reg_write_m (hz.reg_write_m_i),
    .reg_write_w (hz.reg_write_w_i),
    .sel         (hz.forward_b_e_o)
  );

  assign lu = hz.is_load_e_i && (hz.rd_e_i != '0) &&
              ((hz.rd_e_i == hz.rs1_d_i) || (hz.rd_e_i == hz.rs2_d_i));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // The release cycle (WAIT with a zero count) lets M advance without
  // looking at dmem_req, so the next access always starts a fresh wait.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ms      = 1'b0;
    case (state_q)
      RUN: begin
        if (HAS_WAIT && hz.dmem_req_m_i) begin
          ms      = 1'b1;
          state_d = WAIT;
          wait_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (wait_q != '0) begin
          ms     = 1'b1;
          wait_d = wait_q - WAIT_W'(1);
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
  end

  // Memory stall freezes E, so deferred branch/load-use inputs reappear at release.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (ms) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz.pc_src_e_i) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  assign hz.stall_f_o = stall_f;
  assign hz.stall_d_o = stall_d;
  assign hz.stall_e_o = stall_e;
  assign hz.stall_m_o = stall_m;
  assign hz.flush_d_o = flush_d;
  assign hz.flush_e_o = flush_e;
  assign hz.flush_w_o = flush_w;

`ifdef HAZARD_STATS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if ((flush_d || flush_e) && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign hz.stall_cnt_o = stall_cnt_q;
  assign hz.flush_cnt_o = flush_cnt_q;
`else
  assign hz.stall_cnt_o = '0;
  assign hz.flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed testbench for hazard_unit: a default instance (MEM_LATENCY=2) and a
// small one (MEM_LATENCY=0, CNT_WIDTH=4) for single-cycle memory and saturation.
module tb_hazard_unit;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  hazard_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) hz_main ();
  hazard_unit_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(4))  hz_small ();

  hazard_unit #(.REG_ADDR_WIDTH(5), .MEM_LATENCY(2), .CNT_WIDTH(32)) dut_main (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (hz_main)
  );

  hazard_unit #(.REG_ADDR_WIDTH(5), .MEM_LATENCY(0), .CNT_WIDTH(4)) dut_small (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .hz     (hz_small)
  );

  // Control vector order: {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  logic [6:0] ctl_main;
  logic [6:0] ctl_small;
  assign ctl_main  = {hz_main.stall_f_o, hz_main.stall_d_o, hz_main.stall_e_o, hz_main.stall_m_o,
                      hz_main.flush_d_o, hz_main.flush_e_o, hz_main.flush_w_o};
  assign ctl_small = {hz_small.stall_f_o, hz_small.stall_d_o, hz_small.stall_e_o, hz_small.stall_m_o,
                      hz_small.flush_d_o, hz_small.flush_e_o, hz_small.flush_w_o};

  localparam logic [6:0] CTL_IDLE = 7'b0000000;
  localparam logic [6:0] CTL_MEM  = 7'b1111001;
  localparam logic [6:0] CTL_LU   = 7'b1100010;
  localparam logic [6:0] CTL_BR   = 7'b0000110;

  logic [4:0] fw_rs1 [8] = '{5'd5, 5'd5, 5'd5, 5'd3, 5'd9, 5'd0, 5'd12, 5'd31};
  logic [4:0] fw_rs2 [8] = '{5'd6, 5'd6, 5'd6, 5'd9, 5'd9, 5'd0, 5'd12, 5'd30};
  logic [4:0] fw_rdm [8] = '{5'd5, 5'd5, 5'd0, 5'd9, 5'd4, 5'd0, 5'd12, 5'd31};
  logic [4:0] fw_rdw [8] = '{5'd5, 5'd5, 5'd0, 5'd3, 5'd9, 5'd0, 5'd12, 5'd30};
  logic       fw_wm  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       fw_ww  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [1:0] fw_expa[8] = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
  logic [1:0] fw_expb[8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_main();
    hz_main.rs1_d_i       = '0;
    hz_main.rs2_d_i       = '0;
    hz_main.rs1_e_i       = '0;
    hz_main.rs2_e_i       = '0;
    hz_main.rd_e_i        = '0;
    hz_main.is_load_e_i   = 1'b0;
    hz_main.pc_src_e_i    = 1'b0;
    hz_main.rd_m_i        = '0;
    hz_main.rd_w_i        = '0;
    hz_main.reg_write_m_i = 1'b0;
    hz_main.reg_write_w_i = 1'b0;
    hz_main.dmem_req_m_i  = 1'b0;
  endtask

  task automatic clear_small();
    hz_small.rs1_d_i       = '0;
    hz_small.rs2_d_i       = '0;
    hz_small.rs1_e_i       = '0;
    hz_small.rs2_e_i       = '0;
    hz_small.rd_e_i        = '0;
    hz_small.is_load_e_i   = 1'b0;
    hz_small.pc_src_e_i    = 1'b0;
    hz_small.rd_m_i        = '0;
    hz_small.rd_w_i        = '0;
    hz_small.reg_write_m_i = 1'b0;
    hz_small.reg_write_w_i = 1'b0;
    hz_small.dmem_req_m_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_main();
    clear_small();
    #1;
    checks++;
    if (ctl_main !== CTL_IDLE) begin
      failures++;
      $display("[TB] FAIL reset_ctl: got %b expected %b", ctl_main, CTL_IDLE);
    end
    checks++;
    if ({hz_main.forward_a_e_o, hz_main.forward_b_e_o} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_fwd: got %b%b expected 0000", hz_main.forward_a_e_o, hz_main.forward_b_e_o);
    end
    checks++;
    if (hz_main.stall_cnt_o !== 32'd0 || hz_main.flush_cnt_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_cnt: got %0d/%0d expected 0/0", hz_main.stall_cnt_o, hz_main.flush_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear_main();
      hz_main.rs1_e_i       = fw_rs1[i];
      hz_main.rs2_e_i       = fw_rs2[i];
      hz_main.rd_m_i        = fw_rdm[i];
      hz_main.rd_w_i        = fw_rdw[i];
      hz_main.reg_write_m_i = fw_wm[i];
      hz_main.reg_write_w_i = fw_ww[i];
      #1;
      checks++;
      if (hz_main.forward_a_e_o !== fw_expa[i]) begin
        failures++;
        $display("[TB] FAIL fwd_a[%0d]: got %b expected %b", i, hz_main.forward_a_e_o, fw_expa[i]);
      end
      checks++;
      if (hz_main.forward_b_e_o !== fw_expb[i]) begin
        failures++;
        $display("[TB] FAIL fwd_b[%0d]: got %b expected %b", i, hz_main.forward_b_e_o, fw_expb[i]);
      end
      checks++;
      if (ctl_main !== CTL_IDLE) begin
        failures++;
        $display("[TB] FAIL fwd_ctl[%0d]: got %b expected %b", i, ctl_main, CTL_IDLE);
      end
    end
  endtask

  task automatic test_load_use();
    logic [4:0] rd  [5] = '{5'd7, 5'd7, 5'd0, 5'd7, 5'd7};
    logic [4:0] rs1 [5] = '{5'd3, 5'd7, 5'd0, 5'd7, 5'd6};
    logic [4:0] rs2 [5] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd8};
    logic       ld  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [6:0] exp [5] = '{CTL_LU, CTL_LU, CTL_IDLE, CTL_IDLE, CTL_IDLE};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clear_main();
      hz_main.rd_e_i      = rd[i];
      hz_main.rs1_d_i     = rs1[i];
      hz_main.rs2_d_i     = rs2[i];
      hz_main.is_load_e_i = ld[i];
      #1;
      checks++;
      if (ctl_main !== exp[i]) begin
        failures++;
        $display("[TB] FAIL load_use[%0d]: got %b expected %b", i, ctl_main, exp[i]);
      end
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_main();
    hz_main.pc_src_e_i = 1'b1;
    #1;
    checks++;
    if (ctl_main !== CTL_BR) begin
      failures++;
      $display("[TB] FAIL branch: got %b expected %b", ctl_main, CTL_BR);
    end
    @(negedge clk);
    clear_main();
    #1;
    checks++;
    if (ctl_main !== CTL_IDLE) begin
      failures++;
      $display("[TB] FAIL branch_off: got %b expected %b", ctl_main, CTL_IDLE);
    end
  endtask

  task automatic test_mem_wait();
    logic [31:0] exp_stall;
    @(negedge clk);
    rst_n = 1'b0;
    clear_main();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hz_main.dmem_req_m_i = 1'b1;
      #1;
      checks++;
      if (ctl_main !== ((i % 3 == 2) ? CTL_IDLE : CTL_MEM)) begin
        failures++;
        $display("[TB] FAIL mem_wait[%0d]: got %b expected %b", i, ctl_main,
                 (i % 3 == 2) ? CTL_IDLE : CTL_MEM);
      end
    end
    @(negedge clk);
    clear_main();
    #1;
    exp_stall = STATS ? 32'd4 : 32'd0;
    checks++;
    if (hz_main.stall_cnt_o !== exp_stall) begin
      failures++;
      $display("[TB] FAIL mem_stall_cnt: got %0d expected %0d", hz_main.stall_cnt_o, exp_stall);
    end
    checks++;
    if (hz_main.flush_cnt_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL mem_flush_cnt: got %0d expected 0", hz_main.flush_cnt_o);
    end
  endtask

  task automatic test_branch_during_wait();
    logic [31:0] exp_stall;
    logic [31:0] exp_flush;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hz_main.dmem_req_m_i = 1'b1;
      hz_main.pc_src_e_i   = 1'b1;
      #1;
      checks++;
      if (ctl_main !== ((i == 2) ? CTL_BR : CTL_MEM)) begin
        failures++;
        $display("[TB] FAIL br_wait[%0d]: got %b expected %b", i, ctl_main, (i == 2) ? CTL_BR : CTL_MEM);
      end
    end
    @(negedge clk);
    clear_main();
    #1;
    exp_stall = STATS ? 32'd6 : 32'd0;
    exp_flush = STATS ? 32'd1 : 32'd0;
    checks++;
    if (ctl_main !== CTL_IDLE) begin
      failures++;
      $display("[TB] FAIL br_wait_after: got %b expected %b", ctl_main, CTL_IDLE);
    end
    checks++;
    if (hz_main.stall_cnt_o !== exp_stall || hz_main.flush_cnt_o !== exp_flush) begin
      failures++;
      $display("[TB] FAIL br_wait_cnt: got %0d/%0d expected %0d/%0d", hz_main.stall_cnt_o,
               hz_main.flush_cnt_o, exp_stall, exp_flush);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    hz_main.dmem_req_m_i = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ctl_main !== CTL_MEM) begin
      failures++;
      $display("[TB] FAIL rst_wait_pre: got %b expected %b", ctl_main, CTL_MEM);
    end
    #1;
    rst_n = 1'b0;
    hz_main.dmem_req_m_i = 1'b0;
    #1;
    checks++;
    if (ctl_main !== CTL_IDLE) begin
      failures++;
      $display("[TB] FAIL rst_wait_drop: got %b expected %b", ctl_main, CTL_IDLE);
    end
    checks++;
    if (hz_main.stall_cnt_o !== 32'd0 || hz_main.flush_cnt_o !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rst_wait_cnt: got %0d/%0d expected 0/0", hz_main.stall_cnt_o, hz_main.flush_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hz_main.dmem_req_m_i = 1'b1;
      #1;
      checks++;
      if (ctl_main !== ((i == 2) ? CTL_IDLE : CTL_MEM)) begin
        failures++;
        $display("[TB] FAIL rst_wait_post[%0d]: got %b expected %b", i, ctl_main,
                 (i == 2) ? CTL_IDLE : CTL_MEM);
      end
    end
    @(negedge clk);
    clear_main();
  endtask

  task automatic test_single_cycle_mem();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_small();
      hz_small.dmem_req_m_i = 1'b1;
      #1;
      checks++;
      if (ctl_small !== CTL_IDLE) begin
        failures++;
        $display("[TB] FAIL mem0_ctl[%0d]: got %b expected %b", i, ctl_small, CTL_IDLE);
      end
    end
    @(negedge clk);
    clear_small();
  endtask

  task automatic test_stats_saturate();
    logic [3:0] exp_mid;
    logic [3:0] exp_end;
    exp_mid = STATS ? 4'd14 : 4'd0;
    exp_end = STATS ? 4'd15 : 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hz_small.is_load_e_i = 1'b1;
      hz_small.rd_e_i      = 5'd4;
      hz_small.rs1_d_i     = 5'd4;
      #1;
      checks++;
      if (ctl_small !== CTL_LU) begin
        failures++;
        $display("[TB] FAIL sat_ctl[%0d]: got %b expected %b", i, ctl_small, CTL_LU);
      end
      if (i == 14) begin
        checks++;
        if (hz_small.stall_cnt_o !== exp_mid) begin
          failures++;
          $display("[TB] FAIL sat_mid: got %0d expected %0d", hz_small.stall_cnt_o, exp_mid);
        end
      end
    end
    @(negedge clk);
    clear_small();
    #1;
    checks++;
    if (hz_small.stall_cnt_o !== exp_end) begin
      failures++;
      $display("[TB] FAIL sat_stall: got %0d expected %0d", hz_small.stall_cnt_o, exp_end);
    end
    checks++;
    if (hz_small.flush_cnt_o !== exp_end) begin
      failures++;
      $display("[TB] FAIL sat_flush: got %0d expected %0d", hz_small.flush_cnt_o, exp_end);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_during_wait();
    test_reset_mid_wait();
    test_single_cycle_mem();
    test_stats_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
